hazard_ctrl: RTL

Pipeline hazard controller for the decode/exec/writeback core. It drives the stall and flush controls that keep the operand bypass network correct:
- inserts a one-cycle bubble on a load-use dependency that forwarding cannot cover;
- freezes the pipeline while data memory is busy, with a timeout;
- sequences multi-cycle front-end flushes on a taken branch or jump redirect from exec.

---
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the decode/exec/writeback core.
// Drives the stall/flush controls that keep the operand bypass network correct:
//   - one-cycle bubble on a load-use dependency forwarding cannot cover
//   - pipeline freeze while data memory is busy, abandoned after MEM_TIMEOUT
//   - multi-cycle decode flush on a taken branch/jump redirect from exec
// Ports:
//   clk, rstN                    clock, asynchronous active-low reset
//   ra1, ra2, useRs1, useRs2     decode source operands and their use flags
//   decValid                     decode holds a valid instruction
//   execIsLoad, execRd, execValid exec instruction info
//   memReq, memReady             data-memory handshake from exec
//   redirect                     exec resolved a taken branch/jump
//   stallF, stallD, stallE       hold fetch/decode/exec registers
//   bubbleE, flushD              load NOP into exec/decode on next edge
//   memTimeout                   sticky: a memory wait was abandoned
//   busy                         controller is not in RUN
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [4:0] ra1,
    input  logic [4:0] ra2,
    input  logic       useRs1,
    input  logic       useRs2,
    input  logic       decValid,
    input  logic       execIsLoad,
    input  logic [4:0] execRd,
    input  logic       execValid,
    input  logic       memReq,
    input  logic       memReady,
    input  logic       redirect,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       bubbleE,
    output logic       flushD,
    output logic       memTimeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] flush_cnt, flush_cnt_nxt;
    logic       mem_timeout_q;
    logic       timeout_set;
    logic       run_eval;
    logic       load_use;
    logic       mem_block;
    logic       s_f, s_d, s_e, b_e, f_d;

    // x0 is hardwired zero, so it never creates a dependency.
    assign load_use = decValid & execValid & execIsLoad & (execRd != '0) &
                      ((useRs1 & (ra1 == execRd)) | (useRs2 & (ra2 == execRd)));

    assign mem_block = execValid & memReq & ~memReady;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        flush_cnt_nxt = flush_cnt;
        timeout_set   = 1'b0;
        run_eval      = 1'b0;
        s_f           = 1'b0;
        s_d           = 1'b0;
        s_e           = 1'b0;
        b_e           = 1'b0;
        f_d           = 1'b0;

        case (state)
            RUN: run_eval = 1'b1;

            MEM_WAIT: begin
                if (memReady) begin
                    // Released this cycle: the held exec instruction is
                    // evaluated exactly as in RUN.
                    run_eval = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Abandon the wait; any interrupted flush is dropped too.
                    timeout_set   = 1'b1;
                    state_nxt     = RUN;
                    wait_cnt_nxt  = '0;
                    flush_cnt_nxt = '0;
                end else begin
                    s_f          = 1'b1;
                    s_d          = 1'b1;
                    s_e          = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end

            FLUSH: begin
                if (mem_block) begin
                    // Freeze with flush_cnt preserved so the flush resumes.
                    s_f          = 1'b1;
                    s_d          = 1'b1;
                    s_e          = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (redirect) begin
                    f_d           = 1'b1;
                    b_e           = 1'b1;
                    flush_cnt_nxt = FLUSH_RELOAD;
                end else begin
                    f_d = 1'b1;
                    if (flush_cnt <= 3'd1) begin
                        state_nxt     = RUN;
                        flush_cnt_nxt = '0;
                    end else begin
                        flush_cnt_nxt = flush_cnt - 3'd1;
                    end
                end
            end

            default: state_nxt = RUN;
        endcase

        // Shared RUN evaluation, also used on release from MEM_WAIT, which
        // returns to an interrupted flush unless a new redirect supersedes it.
        if (run_eval) begin
            wait_cnt_nxt = '0;
            state_nxt    = (state == MEM_WAIT && flush_cnt != '0) ? FLUSH : RUN;
            if (mem_block) begin
                s_f          = 1'b1;
                s_d          = 1'b1;
                s_e          = 1'b1;
                state_nxt    = MEM_WAIT;
                wait_cnt_nxt = 8'd1;
            end else if (redirect) begin
                f_d = 1'b1;
                b_e = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FLUSH_RELOAD;
                end else begin
                    state_nxt     = RUN;
                    flush_cnt_nxt = '0;
                end
            end else if (load_use) begin
                s_f = 1'b1;
                s_d = 1'b1;
                b_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= RUN;
            wait_cnt      <= '0;
            flush_cnt     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            flush_cnt     <= flush_cnt_nxt;
            mem_timeout_q <= mem_timeout_q | timeout_set;
        end
    end

    // Combinational controls are forced low while reset is asserted.
    assign stallF     = rstN & s_f;
    assign stallD     = rstN & s_d;
    assign stallE     = rstN & s_e;
    assign bubbleE    = rstN & b_e;
    assign flushD     = rstN & f_d;
    assign memTimeout = rstN & mem_timeout_q;
    assign busy       = rstN & (state != RUN);

endmodule
